// File: rtl/alu_link_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_link_pkg: shared state encoding, frame marker and status codes. Rev 1.0
// ----------------------------------------------------------------------------
package alu_link_pkg;

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_A      = 3'd1,
    S_B      = 3'd2,
    S_OPC    = 3'd3,
    S_CHK    = 3'd4,
    S_EXEC   = 3'd5,
    S_WR_RES = 3'd6,
    S_WR_ST  = 3'd7
  } link_state_t;

  localparam logic [7:0] LINK_HDR_BYTE = 8'hA5;

  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_CHK = 8'h01;
  localparam logic [7:0] ST_TMO = 8'h02;

endpackage
`default_nettype wire

// File: rtl/link_timeout_ctr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// link_timeout_ctr: inter-byte down-counter; expires after TIMEOUT_CYCLES idle. Rev 1.0
// ----------------------------------------------------------------------------
module link_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Loading TIMEOUT_CYCLES-1 makes the TIMEOUT_CYCLES-th idle cycle the expiring one.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = run && (count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_cmd_sequencer: 5-byte RX command frame -> ALU -> 2-byte TX response. Rev 1.0
// ----------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_link_pkg::*;
#(
  parameter int                    WORD_WIDTH     = 8,
  parameter int                    OPC_WIDTH      = 6,
  parameter logic [WORD_WIDTH-1:0] HDR_BYTE       = WORD_WIDTH'(LINK_HDR_BYTE),
  parameter int                    TIMEOUT_CYCLES = 100000,
  parameter int                    ALU_LATENCY    = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rxff_empty,
  input  logic [WORD_WIDTH-1:0] i_rxff_data,
  output logic                  o_rxff_read,
  input  logic                  i_txff_full,
  output logic [WORD_WIDTH-1:0] o_txff_data,
  output logic                  o_txff_write,
  output logic [WORD_WIDTH-1:0] o_operand_a,
  output logic [WORD_WIDTH-1:0] o_operand_b,
  output logic [OPC_WIDTH-1:0]  o_opcode,
  input  logic [WORD_WIDTH-1:0] i_result,
  output logic                  o_busy
);

  localparam int LAT_W = $clog2(ALU_LATENCY + 1);

  link_state_t           state;
  logic [WORD_WIDTH-1:0] chk;
  logic [WORD_WIDTH-1:0] status;
  logic [WORD_WIDTH-1:0] result;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  in_frame;
  logic                  take;
  logic                  tmo_expired;

  assign in_frame = state inside {S_A, S_B, S_OPC, S_CHK};
  // The pop strobe must coincide with the sample, so it is decoded from state and the empty flag.
  assign take         = (in_frame || (state == S_HDR)) && !i_rxff_empty;
  assign o_rxff_read  = take;
  assign o_txff_write = ((state == S_WR_RES) || (state == S_WR_ST)) && !i_txff_full;
  assign o_txff_data  = (state == S_WR_ST) ? status : result;
  assign o_busy       = (state != S_HDR);

  link_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .load    (take),
    .run     (in_frame && i_rxff_empty),
    .expired (tmo_expired)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_HDR;
      chk         <= '0;
      status      <= '0;
      result      <= '0;
      lat_cnt     <= '0;
      o_operand_a <= '0;
      o_operand_b <= '0;
      o_opcode    <= '0;
    end else begin
      case (state)
        S_HDR: begin
          if (take && (i_rxff_data == HDR_BYTE)) begin
            chk   <= '0;
            state <= S_A;
          end
        end
        S_A, S_B, S_OPC, S_CHK: begin
          if (take) begin
            case (state)
              S_A: begin
                o_operand_a <= i_rxff_data;
                chk         <= chk ^ i_rxff_data;
                state       <= S_B;
              end
              S_B: begin
                o_operand_b <= i_rxff_data;
                chk         <= chk ^ i_rxff_data;
                state       <= S_OPC;
              end
              S_OPC: begin
                o_opcode <= i_rxff_data[OPC_WIDTH-1:0];
                chk      <= chk ^ i_rxff_data;
                state    <= S_CHK;
              end
              default: begin
                status  <= (i_rxff_data == chk) ? WORD_WIDTH'(ST_OK) : WORD_WIDTH'(ST_CHK);
                lat_cnt <= '0;
                state   <= S_EXEC;
              end
            endcase
          end else if (tmo_expired) begin
            status <= WORD_WIDTH'(ST_TMO);
            result <= '0;
            state  <= S_WR_RES;
          end
        end
        S_EXEC: begin
          if (lat_cnt == LAT_W'(ALU_LATENCY - 1)) begin
            result <= (status == WORD_WIDTH'(ST_OK)) ? i_result : '0;
            state  <= S_WR_RES;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_WR_RES: begin
          if (!i_txff_full) state <= S_WR_ST;
        end
        S_WR_ST: begin
          if (!i_txff_full) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer: randomized frames against a queue-based link model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
  import alu_link_pkg::*;

  localparam int TMO = 20;
  localparam int LAT = 2;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rd;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       wr;
  logic [7:0] opa;
  logic [7:0] opb;
  logic [5:0] opc;
  logic [7:0] alu_res;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int cyc = 0;
  bit rand_full = 1'b0;
  bit force_full = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] alu_pipe[LAT];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .WORD_WIDTH(8), .OPC_WIDTH(6), .HDR_BYTE(LINK_HDR_BYTE),
    .TIMEOUT_CYCLES(TMO), .ALU_LATENCY(LAT)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_rxff_empty(rx_empty), .i_rxff_data(rx_data), .o_rxff_read(rd),
    .i_txff_full(tx_full), .o_txff_data(tx_data), .o_txff_write(wr),
    .o_operand_a(opa), .o_operand_b(opb), .o_opcode(opc),
    .i_result(alu_res), .o_busy(busy)
  );

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return {a[3:0], b[3:0]};
    endcase
  endfunction

  // ALU with LAT register stages after the operands
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(opa, opb, opc);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_res = alu_pipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_full = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
    end
  end

  // Reference link model: consumes the popped byte stream and predicts TX bytes
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] c;
    frame_q.push_back(b);
    if (frame_q[0] != LINK_HDR_BYTE) begin
      frame_q.delete();
    end else if (frame_q.size() == 5) begin
      c = frame_q[1] ^ frame_q[2] ^ frame_q[3];
      if (c == frame_q[4]) begin
        exp_q.push_back(alu_fn(frame_q[1], frame_q[2], frame_q[3][5:0]));
        exp_q.push_back(ST_OK);
      end else begin
        exp_q.push_back(8'h00);
        exp_q.push_back(ST_CHK);
      end
      frame_q.delete();
    end
  endtask

  task automatic model_timeout();
    frame_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(ST_TMO);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rd) begin
        pops++;
        vectors++;
        if (rx_empty) begin
          miscompares++;
          $display("FAIL rx_read_when_empty: got read=1 required 0");
        end
      end
      if (wr) begin
        vectors++;
        if (tx_full) begin
          miscompares++;
          $display("FAIL tx_write_when_full: got write=1 required 0");
        end else if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_tx_write: got %0h required no write", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            miscompares++;
            $display("FAIL tx_data: got %0h required %0h", tx_data, e);
          end
        end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    rx_empty = 1'b1;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_empty = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      got = rd;
      @(posedge clk);
      #1;
    end
    rx_empty = 1'b1;
    if (got) model_byte(b);
    else check("rx_pop_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input bit good, input int gmax);
    logic [7:0] c;
    c = a ^ b ^ op;
    if (!good) c = c ^ 8'($urandom_range(1, 255));
    send_byte(LINK_HDR_BYTE, $urandom_range(0, gmax));
    send_byte(a, $urandom_range(0, gmax));
    send_byte(b, $urandom_range(0, gmax));
    send_byte(op, $urandom_range(0, gmax));
    send_byte(c, $urandom_range(0, gmax));
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < BUDGET && !done; i++) begin
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int p0;
    int t0;
    int tw;
    bit seen_rd;
    bit unstable;
    logic [7:0] d0;
    logic [7:0] g;
    logic [7:0] ops[5];
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;

    rst = 1'b1; rx_empty = 1'b1; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rd, wr, tx_data, opa, opb, opc, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: good ADD frame, five pops
    p0 = pops;
    send_frame(8'h05, 8'h03, 8'h20, 1'b1, 0);
    wait_drain();
    check("frame_pop_count", 32'(pops - p0), 32'd5);

    // 2: checksum error keeps operands driven
    send_frame(8'h05, 8'h03, 8'h20, 1'b0, 0);
    wait_drain();
    check("chkerr_operands", {opa, opb, 2'b00, opc}, {8'h05, 8'h03, 8'h20});

    // 3: junk before header
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_frame(8'h0A, 8'h01, 8'h22, 1'b1, 1);
    wait_drain();

    // 4: inter-byte timeout, then a normal frame
    send_byte(LINK_HDR_BYTE, 0);
    send_byte(8'h05, 0);
    t0 = cyc;
    model_timeout();
    tw = -1;
    for (int i = 0; i < TMO + 20 && tw < 0; i++) begin
      @(negedge clk);
      if (wr) tw = cyc + 1;
    end
    @(posedge clk); #1;
    vectors++;
    if (tw < 0 || (tw - t0) < TMO || (tw - t0) > TMO + 2) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d required %0d..%0d", tw - t0, TMO, TMO + 2);
    end
    wait_drain();
    check("timeout_operands", {opa, opb}, {8'h05, 8'h01});
    send_frame(8'h40, 8'h02, 8'h20, 1'b1, 0);
    wait_drain();

    // 5: TX full stall
    force_full = 1'b1;
    send_frame(8'h11, 8'h22, 8'h25, 1'b1, 0);
    repeat (LAT + 3) begin @(posedge clk); #1; end
    @(negedge clk);
    d0 = tx_data;
    seen_rd = 1'b0; unstable = 1'b0;
    rx_data = LINK_HDR_BYTE; rx_empty = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (rd) seen_rd = 1'b1;
      if (tx_data !== d0) unstable = 1'b1;
    end
    @(posedge clk); #1;
    rx_empty = 1'b1;
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_rx_pop", 32'(seen_rd), 32'd0);
    check("stall_data_stable", 32'(unstable), 32'd0);
    check("stall_data_value", 32'(d0), 32'(alu_fn(8'h11, 8'h22, 6'h25)));
    force_full = 1'b0;
    wait_drain();

    // 6: reset while in S_OPC abandons the frame
    send_byte(LINK_HDR_BYTE, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    frame_q.delete();
    check("reset_midframe_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h12, 8'h34, 8'h24, 1'b1, 0);
    wait_drain();

    // Randomized traffic with random TX back-pressure
    rand_full = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom);
        if (g == LINK_HDR_BYTE) g = 8'h5A;
        send_byte(g, $urandom_range(0, 3));
      end
      send_frame(8'($urandom), 8'($urandom),
                 {2'($urandom), (($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)][5:0])},
                 ($urandom_range(0, 4) != 0), 3);
    end
    wait_drain();
    rand_full = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
